// File: rtl/apb_demux_pkg.sv
// Shared definitions for the APB demux bridge: FSM state encoding and APB response codes.
package apb_demux_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    RESP   = 3'd3,
    ERR    = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  localparam logic OKAY   = 1'b0;
  localparam logic SLVERR = 1'b1;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog for apb_demux_bridge; only instantiated when APB_DEMUX_TIMEOUT_EN is defined.
module apb_timeout_cnt
  import apb_demux_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  // Saturates at LAST so a lingering enable can never wrap back to zero.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 16'd1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/apb_demux_bridge.sv
// Converts a single-phase upstream APB request into two-phase transfers to NUM_SLAVES regions.
// Define APB_DEMUX_TIMEOUT_EN to include the ACCESS watchdog (apb_timeout_cnt).
module apb_demux_bridge
  import apb_demux_pkg::*;
#(
  parameter int NUM_SLAVES      = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SLAVE_ADDR_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h4000_0000,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                             ACLK,
  input  logic                             ARESETn,
  input  logic                             s_psel,
  input  logic                             s_penable,
  input  logic                             s_pwrite,
  input  logic [ADDR_WIDTH-1:0]            s_paddr,
  input  logic [DATA_WIDTH-1:0]            s_pwdata,
  output logic [DATA_WIDTH-1:0]            s_prdata,
  output logic                             s_pready,
  output logic                             s_pslverr,
  output logic [NUM_SLAVES-1:0]            m_psel,
  output logic                             m_penable,
  output logic                             m_pwrite,
  output logic [ADDR_WIDTH-1:0]            m_paddr,
  output logic [DATA_WIDTH-1:0]            m_pwdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_prdata,
  input  logic [NUM_SLAVES-1:0]            m_pready,
  input  logic [NUM_SLAVES-1:0]            m_pslverr,
  output logic                             timeout_o
);

  localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int HI_LSB = SLAVE_ADDR_BITS + IDX_W;

  state_t                     state, state_nxt;
  logic                       lat_write;
  logic [DATA_WIDTH-1:0]      lat_wdata;
  logic [SLAVE_ADDR_BITS-1:0] lat_off;
  logic [IDX_W-1:0]           lat_idx;
  logic [DATA_WIDTH-1:0]      cap_rdata;
  logic                       cap_slverr;
  logic                       timeout_q;

  logic                       req;
  logic                       hit;
  logic [IDX_W-1:0]           req_idx;
  logic                       sel_ready;
  logic [DATA_WIDTH-1:0]      sel_rdata;
  logic                       watchdog_expired;
  logic                       timeout_fire;

  assign req       = s_psel && s_penable;
  assign req_idx   = s_paddr[SLAVE_ADDR_BITS +: IDX_W];
  assign hit       = (((s_paddr ^ BASE_ADDR) >> HI_LSB) == '0) && (32'(req_idx) < NUM_SLAVES);
  assign sel_ready = m_pready[lat_idx];
  assign sel_rdata = m_prdata[32'(lat_idx) * DATA_WIDTH +: DATA_WIDTH];

`ifdef APB_DEMUX_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .clear   (state == SETUP),
    .enable  (state == ACCESS),
    .expired (watchdog_expired)
  );
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES == 0);
  assign watchdog_expired      = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // pready beats watchdog expiry when both land in the same ACCESS cycle.
  always_comb begin
    state_nxt    = state;
    timeout_fire = 1'b0;
    case (state)
      IDLE:   if (req) state_nxt = hit ? SETUP : ERR;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          state_nxt = RESP;
        end else if (watchdog_expired) begin
          state_nxt    = RESP;
          timeout_fire = 1'b1;
        end
      end
      RESP:   state_nxt = DRAIN;
      ERR:    state_nxt = DRAIN;
      DRAIN:  if (!s_penable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      lat_write  <= 1'b0;
      lat_wdata  <= '0;
      lat_off    <= '0;
      lat_idx    <= '0;
      cap_rdata  <= '0;
      cap_slverr <= OKAY;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= timeout_fire;
      if ((state == IDLE) && req) begin
        lat_write <= s_pwrite;
        lat_wdata <= s_pwdata;
        lat_off   <= s_paddr[SLAVE_ADDR_BITS-1:0];
        lat_idx   <= req_idx;
      end
      if (state == ACCESS) begin
        if (sel_ready) begin
          cap_rdata  <= lat_write ? '0 : sel_rdata;
          cap_slverr <= m_pslverr[lat_idx];
        end else if (watchdog_expired) begin
          cap_rdata  <= '0;
          cap_slverr <= SLVERR;
        end
      end
    end
  end

  // Every output is a decode of registered state, so no input reaches an output combinationally.
  always_comb begin
    m_psel    = '0;
    m_penable = 1'b0;
    s_pready  = 1'b0;
    s_prdata  = '0;
    s_pslverr = OKAY;
    case (state)
      SETUP:  m_psel = NUM_SLAVES'(1) << lat_idx;
      ACCESS: begin
        m_psel    = NUM_SLAVES'(1) << lat_idx;
        m_penable = 1'b1;
      end
      RESP: begin
        s_pready  = 1'b1;
        s_prdata  = cap_rdata;
        s_pslverr = cap_slverr;
      end
      ERR: begin
        s_pready  = 1'b1;
        s_pslverr = SLVERR;
      end
      default: ;
    endcase
  end

  assign m_pwrite  = lat_write;
  assign m_pwdata  = lat_wdata;
  assign m_paddr   = ADDR_WIDTH'(lat_off);
  assign timeout_o = timeout_q;

endmodule
